// File: rtl/fwd_hazard_scoreboard.sv
// Purpose: operand forwarding selects, load-use / multi-cycle hazard detection, stall-cycle counter.
// Latency: fwd_sel/stall/bubble are combinational; mul_busy/mul_rd/stall_cycles are registered.
// Backpressure: stall holds PC and IF/ID, bubble inserts a NOP into ID/EX; id_flush overrides both.
module fwd_hazard_scoreboard #(
   parameter int REG_AW   = 5,
   parameter int NSRC     = 2,
   parameter int MUL_LAT  = 3,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [NSRC*REG_AW-1:0] id_src,
   input  logic [REG_AW-1:0]      id_rd,
   input  logic                   id_regwrite,
   input  logic                   id_is_mul,
   input  logic                   id_flush,
   input  logic [NSRC*REG_AW-1:0] ex_src,
   input  logic [REG_AW-1:0]      ex_rd,
   input  logic                   ex_regwrite,
   input  logic                   ex_memread,
   input  logic [REG_AW-1:0]      mem_rd,
   input  logic                   mem_regwrite,
   input  logic [REG_AW-1:0]      wb_rd,
   input  logic                   wb_regwrite,
   output logic [NSRC*2-1:0]      fwd_sel,
   output logic                   stall,
   output logic                   bubble,
   output logic                   mul_busy,
   output logic [REG_AW-1:0]      mul_rd,
   output logic [CNT_W-1:0]       stall_cycles
);

   // Counter is 4 bits wide, enough for the 1..15 latency range.
   localparam logic [3:0] MulLat = 4'(MUL_LAT);
   localparam logic [REG_AW-1:0] RegZero = '0;

   logic [3:0] mulCnt;
   logic       loadUse;
   logic       mulRaw;
   logic       mulWaw;
   logic       mulStruct;
   logic       idLive;
   logic       issue;
   logic       mulLoad;

   // Register 0 is hardwired when ZERO_REG is set, so it never counts as a dependency.
   function automatic logic regMatch(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a == b) && !((ZERO_REG != 0) && (a == RegZero));
   endfunction

   // Per-operand forwarding select; the younger EX/MEM result wins over MEM/WB.
   always_comb begin
      fwd_sel = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (mem_regwrite && regMatch(mem_rd, ex_src[k*REG_AW +: REG_AW])) begin
            fwd_sel[k*2 +: 2] = 2'b01;
         end else if (wb_regwrite && regMatch(wb_rd, ex_src[k*REG_AW +: REG_AW])) begin
            fwd_sel[k*2 +: 2] = 2'b10;
         end
      end
   end

   // Hazard terms against the instruction in ID; a flushed ID slot never stalls.
   always_comb begin
      idLive    = id_valid && !id_flush;
      loadUse   = 1'b0;
      mulRaw    = 1'b0;
      for (int k = 0; k < NSRC; k++) begin
         if (ex_memread && ex_regwrite && regMatch(ex_rd, id_src[k*REG_AW +: REG_AW])) begin
            loadUse = 1'b1;
         end
         if (mul_busy && regMatch(mul_rd, id_src[k*REG_AW +: REG_AW])) begin
            mulRaw = 1'b1;
         end
      end
      mulWaw    = mul_busy && id_regwrite && regMatch(mul_rd, id_rd);
      mulStruct = mul_busy && id_is_mul;
      stall     = idLive && (loadUse || mulRaw || mulWaw || mulStruct);
      bubble    = stall;
      issue     = idLive && !stall;
      // A multiply targeting r0 has no visible result, so it is not tracked.
      mulLoad   = issue && id_is_mul && id_regwrite &&
                  !((ZERO_REG != 0) && (id_rd == RegZero));
   end

   assign mul_busy = (mulCnt != 4'd0);

   // Single-entry scoreboard: load on multiply issue, otherwise count down to retirement.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mulCnt <= 4'd0;
         mul_rd <= '0;
      end else if (mulLoad) begin
         mulCnt <= MulLat;
         mul_rd <= id_rd;
      end else if (mulCnt != 4'd0) begin
         mulCnt <= mulCnt - 4'd1;
      end
   end

   // Saturating performance counter of cycles spent stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
         stall_cycles <= stall_cycles + 1'b1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Purpose: directed self-checking bench for fwd_hazard_scoreboard (default and CNT_W=4 instances).
// Latency: inputs change 1 time unit after a rising edge, checks follow 1 unit later.
// Backpressure: not applicable; stimulus is a fixed directed sequence.
module tb_fwd_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [9:0]  id_src;
   logic [4:0]  id_rd;
   logic        id_regwrite;
   logic        id_is_mul;
   logic        id_flush;
   logic [9:0]  ex_src;
   logic [4:0]  ex_rd;
   logic        ex_regwrite;
   logic        ex_memread;
   logic [4:0]  mem_rd;
   logic        mem_regwrite;
   logic [4:0]  wb_rd;
   logic        wb_regwrite;
   logic [3:0]  fwd_sel;
   logic        stall;
   logic        bubble;
   logic        mul_busy;
   logic [4:0]  mul_rd;
   logic [15:0] stall_cycles;
   logic [3:0]  satFwdSel;
   logic        satStall;
   logic        satBubble;
   logic        satMulBusy;
   logic [4:0]  satMulRd;
   logic [3:0]  satStallCycles;

   int checkCnt = 0;
   int errorCnt = 0;

   always #5 clk = ~clk;

   fwd_hazard_scoreboard dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_mul(id_is_mul), .id_flush(id_flush),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .fwd_sel(fwd_sel), .stall(stall), .bubble(bubble), .mul_busy(mul_busy),
      .mul_rd(mul_rd), .stall_cycles(stall_cycles)
   );

   fwd_hazard_scoreboard #(.CNT_W(4)) dutSat (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
      .id_regwrite(id_regwrite), .id_is_mul(id_is_mul), .id_flush(id_flush),
      .ex_src(ex_src), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .fwd_sel(satFwdSel), .stall(satStall), .bubble(satBubble), .mul_busy(satMulBusy),
      .mul_rd(satMulRd), .stall_cycles(satStallCycles)
   );

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCnt++;
      if (got !== exp) begin
         errorCnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clearInputs();
      id_valid = 0; id_src = '0; id_rd = '0; id_regwrite = 0; id_is_mul = 0; id_flush = 0;
      ex_src = '0; ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
      mem_rd = '0; mem_regwrite = 0; wb_rd = '0; wb_regwrite = 0;
   endtask

   // Advance one rising edge and land 1 unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a multiply writing rd, let it issue on the next edge.
   task automatic issueMul(input logic [4:0] rd);
      id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = rd; id_src = '0; id_flush = 0;
      #1;
      checkVal("mul_issue_nostall", 32'(stall), 32'd0);
      tick();
      id_valid = 0; id_is_mul = 0; id_regwrite = 0; id_rd = '0;
   endtask

   initial begin
      clearInputs();
      rst_n = 0;
      tick();
      tick();
      checkVal("rst_mul_busy", 32'(mul_busy), 32'd0);
      checkVal("rst_mul_rd", 32'(mul_rd), 32'd0);
      checkVal("rst_stall_cycles", 32'(stall_cycles), 32'd0);
      checkVal("rst_fwd_sel", 32'(fwd_sel), 32'd0);
      checkVal("rst_stall", 32'(stall), 32'd0);
      checkVal("rst_bubble", 32'(bubble), 32'd0);
      rst_n = 1;

      // Forwarding priority and r0 suppression.
      ex_src = {5'd0, 5'd3}; mem_rd = 5'd3; mem_regwrite = 1; wb_rd = 5'd3; wb_regwrite = 1;
      #1 checkVal("fwd_mem_prio", 32'(fwd_sel), 32'h1);
      mem_regwrite = 0;
      #1 checkVal("fwd_wb", 32'(fwd_sel), 32'h2);
      mem_rd = 5'd0; mem_regwrite = 1;
      #1 checkVal("fwd_r0_suppressed", 32'(fwd_sel), 32'h2);
      ex_src = {5'd6, 5'd1}; mem_rd = 5'd6; wb_rd = 5'd6;
      #1 checkVal("fwd_src1_mem", 32'(fwd_sel), 32'h4);
      clearInputs();

      // Load-use on operand 1, then flush override.
      ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_valid = 1; id_src = {5'd5, 5'd0};
      #1;
      checkVal("lu_stall", 32'(stall), 32'd1);
      checkVal("lu_bubble", 32'(bubble), 32'd1);
      checkVal("lu_cnt_before", 32'(stall_cycles), 32'd0);
      tick();
      checkVal("lu_cnt_after", 32'(stall_cycles), 32'd1);
      id_flush = 1;
      #1;
      checkVal("lu_flush_stall", 32'(stall), 32'd0);
      checkVal("lu_flush_bubble", 32'(bubble), 32'd0);
      tick();
      checkVal("lu_flush_cnt", 32'(stall_cycles), 32'd1);
      clearInputs();

      // Multiply RAW: dependent instruction stalls exactly MUL_LAT cycles.
      issueMul(5'd7);
      checkVal("raw_mul_rd", 32'(mul_rd), 32'd7);
      id_valid = 1; id_regwrite = 1; id_rd = 5'd8; id_src = {5'd0, 5'd7};
      for (int i = 0; i < 3; i++) begin
         #1;
         checkVal($sformatf("raw_stall_c%0d", i + 1), 32'(stall), 32'd1);
         checkVal($sformatf("raw_busy_c%0d", i + 1), 32'(mul_busy), 32'd1);
         tick();
      end
      checkVal("raw_busy_done", 32'(mul_busy), 32'd0);
      checkVal("raw_stall_done", 32'(stall), 32'd0);
      checkVal("raw_cnt", 32'(stall_cycles), 32'd4);
      tick();
      clearInputs();

      // Structural and WAW hazards against an in-flight multiply to r9.
      issueMul(5'd9);
      id_valid = 1; id_is_mul = 1; id_regwrite = 1; id_rd = 5'd10;
      #1 checkVal("struct_stall", 32'(stall), 32'd1);
      id_is_mul = 0; id_rd = 5'd9;
      #1 checkVal("waw_stall", 32'(stall), 32'd1);
      id_rd = 5'd4; id_src = {5'd2, 5'd1};
      #1 checkVal("unrelated_nostall", 32'(stall), 32'd0);
      clearInputs();
      for (int i = 0; i < 3; i++) tick();
      checkVal("struct_retired", 32'(mul_busy), 32'd0);

      // Flush does not cancel an issued multiply.
      issueMul(5'd11);
      id_valid = 1; id_flush = 1; id_src = {5'd0, 5'd11};
      #1 checkVal("flush_mul_nostall", 32'(stall), 32'd0);
      tick();
      checkVal("flush_mul_busy", 32'(mul_busy), 32'd1);
      clearInputs();
      for (int i = 0; i < 2; i++) tick();
      checkVal("flush_mul_retired", 32'(mul_busy), 32'd0);

      // Reset in the middle of a multiply.
      issueMul(5'd7);
      checkVal("mid_busy", 32'(mul_busy), 32'd1);
      rst_n = 0;
      tick();
      rst_n = 1;
      checkVal("mid_rst_busy", 32'(mul_busy), 32'd0);
      checkVal("mid_rst_cnt", 32'(stall_cycles), 32'd0);
      id_valid = 1; id_regwrite = 1; id_rd = 5'd8; id_src = {5'd0, 5'd7};
      #1 checkVal("mid_rst_nostall", 32'(stall), 32'd0);
      clearInputs();
      tick();

      // Saturation of the 4-bit counter under a held load-use hazard.
      rst_n = 0;
      tick();
      rst_n = 1;
      ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_valid = 1; id_src = {5'd0, 5'd5};
      for (int i = 0; i < 15; i++) tick();
      checkVal("sat_at15", 32'(satStallCycles), 32'd15);
      for (int i = 0; i < 5; i++) tick();
      checkVal("sat_held", 32'(satStallCycles), 32'd15);
      checkVal("wide_cnt20", 32'(stall_cycles), 32'd20);
      clearInputs();

      $display("CHECKS %0d ERRORS %0d", checkCnt, errorCnt);
      $finish;
   end

endmodule
